// File: rtl/bcd_onehot_seq_decoder.sv
// Multi-digit BCD to one-hot decoder. It decodes one digit per clock through a single 4-to-10 stage.
// The optional saturating invalid-digit counter is enabled by defining BCD_DEC_ERR_CNT_EN.
`timescale 1ns/1ps
module bcd_onehot_seq_decoder #(
    parameter int DIGITS      = 4,
    parameter bit ACTIVE_HIGH = 1'b1,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [10*DIGITS-1:0]  out_onehot,
    output logic [DIGITS-1:0]     out_err,
    output logic                  busy
`ifdef BCD_DEC_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

    localparam int         IDX_W    = $clog2(DIGITS + 1);
    localparam logic [9:0] INACTIVE = ACTIVE_HIGH ? 10'h000 : 10'h3FF;

    typedef enum logic [1:0] {IDLE, DECODE, OUT} state_t;

    if (DIGITS < 1 || ERR_CNT_W < 1) begin : g_bad_param
        $error("bcd_onehot_seq_decoder: DIGITS and ERR_CNT_W must be >= 1");
    end

    function automatic logic [9:0] decode_digit(input logic [3:0] v);
        logic [9:0] hot;
        hot = '0;
        if (v <= 4'd9) hot[4'd9 - v] = 1'b1;
        return ACTIVE_HIGH ? hot : ~hot;
    endfunction

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [4*DIGITS-1:0]  sreg;
    logic [9:0]           dig_hot;
    logic                 dig_bad;
    logic                 accept;

    always_comb begin
        dig_hot = decode_digit(sreg[3:0]);
        dig_bad = (sreg[3:0] > 4'd9);
    end

    assign accept = (state == IDLE) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)                    state_nxt = DECODE;
            DECODE:  if (idx == IDX_W'(DIGITS - 1))   state_nxt = OUT;
            OUT:     if (out_ready)                   state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    // Digit shift register: data only, needs no reset
    always_ff @(posedge clk) begin
        if (accept)                sreg <= in_bcd;
        else if (state == DECODE)  sreg <= sreg >> 4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            out_onehot <= {DIGITS{INACTIVE}};
            out_err    <= '0;
        end else if (accept) begin
            idx        <= '0;
            out_onehot <= {DIGITS{INACTIVE}};
            out_err    <= '0;
        end else if (state == DECODE) begin
            idx <= idx + IDX_W'(1);
            for (int k = 0; k < DIGITS; k++) begin
                if (idx == IDX_W'(k)) begin
                    out_onehot[10*k +: 10] <= dig_hot;
                    out_err[k]             <= dig_bad;
                end
            end
        end
    end

`ifdef BCD_DEC_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (state == DECODE && dig_bad && err_cnt != {ERR_CNT_W{1'b1}})
            err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
`endif

endmodule
